// File: rtl/matrix_3x3_gen_pkg.sv
// Shared defaults and window geometry for the 3x3 window generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package matrix_3x3_gen_pkg;

  // Default geometry: VGA-sized 8-bit luma.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_ADDR_WIDTH = 10;

  // Window is WIN_SIZE x WIN_SIZE.
  localparam int WIN_SIZE = 3;

  // Index of the newest row/column inside the window. It is also the first
  // row/col position at which a complete window exists.
  localparam int WIN_LAST = WIN_SIZE - 1;

endpackage

// File: rtl/matrix_3x3_gen_line_delay.sv
// One-line delay: returns the sample accepted exactly IMG_WIDTH enables ago.
// Latency: IMG_WIDTH enabled samples; the tap is read combinationally before the write.
// Backpressure: none; en low freezes pointer, contents and tap.
module line_delay
  import matrix_3x3_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  I_CLK,
  input  logic                  I_Rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Contents are intentionally not reset: the row gating in the parent
  // prevents stale samples from ever reaching a valid window.
  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // The slot about to be overwritten holds the sample from one line ago.
  assign dout = mem[ptr_q];

  // Circular pointer advances one slot per accepted sample.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == ADDR_WIDTH'(IMG_WIDTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // RAM write into the slot just read.
  always_ff @(posedge I_CLK) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Raster-scan 3x3 neighbourhood generator built from two line delays and per-row shift registers.
// Latency: window and O_de appear one cycle after the pixel that completes it (bottom-right pixel).
// Backpressure: none; I_de gates all state, one pixel per cycle sustained.
module matrix_3x3_gen
  import matrix_3x3_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  I_CLK,
  input  logic                  I_Rst_n,
  input  logic                  I_vsync,
  input  logic                  I_de,
  input  logic [DATA_WIDTH-1:0] I_data,
  output logic                  O_de,
  output logic                  O_vsync,
  output logic [DATA_WIDTH-1:0] O_m11,
  output logic [DATA_WIDTH-1:0] O_m12,
  output logic [DATA_WIDTH-1:0] O_m13,
  output logic [DATA_WIDTH-1:0] O_m21,
  output logic [DATA_WIDTH-1:0] O_m22,
  output logic [DATA_WIDTH-1:0] O_m23,
  output logic [DATA_WIDTH-1:0] O_m31,
  output logic [DATA_WIDTH-1:0] O_m32,
  output logic [DATA_WIDTH-1:0] O_m33
);

  // Row counter needs to hold 0..IMG_HEIGHT-1; +1 keeps the width non-zero
  // for tiny test geometries.
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

  // Raster position of the pixel currently on the input.
  logic [ADDR_WIDTH-1:0] col_q;
  logic [ADDR_WIDTH-1:0] col_d;
  logic [ADDR_WIDTH-1:0] col_cur;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W-1:0]      row_d;
  logic [ROW_W-1:0]      row_cur;

  // Vertical taps: index 0 = two lines ago (window row 1), WIN_LAST = live input.
  logic [DATA_WIDTH-1:0] line1_dat;
  logic [DATA_WIDTH-1:0] line2_dat;
  logic [DATA_WIDTH-1:0] tap [WIN_SIZE];

  // Per-row horizontal shift registers, [row][col], col WIN_LAST newest.
  logic [DATA_WIDTH-1:0] sr_q [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0] sr_d [WIN_SIZE][WIN_SIZE];

  // Published window; only updated when a complete window is produced so the
  // outputs hold steady between valid windows.
  logic [DATA_WIDTH-1:0] win_q [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0] win_d [WIN_SIZE][WIN_SIZE];

  logic win_vld;
  logic de_q;
  logic de_d;
  logic vs_q;
  logic vs_d;

  line_delay #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_line_delay_1 (
    .I_CLK   (I_CLK),
    .I_Rst_n (I_Rst_n),
    .en      (I_de),
    .din     (I_data),
    .dout    (line1_dat)
  );

  line_delay #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_line_delay_2 (
    .I_CLK   (I_CLK),
    .I_Rst_n (I_Rst_n),
    .en      (I_de),
    .din     (line1_dat),
    .dout    (line2_dat)
  );

  // Gather the three vertical taps, oldest line first.
  always_comb begin
    tap[0]        = line2_dat;
    tap[1]        = line1_dat;
    tap[WIN_LAST] = I_data;
  end

  // Raster position tracking; a vsync pulse makes the coincident pixel (0,0).
  always_comb begin
    col_cur = I_vsync ? '0 : col_q;
    row_cur = I_vsync ? '0 : row_q;
    col_d   = col_cur;
    row_d   = row_cur;
    win_vld = 1'b0;
    if (I_de) begin
      // Rows 0-1 and cols 0-1 lack a full neighbourhood; this gate is also
      // what keeps stale line-delay data and a previous partial line out.
      win_vld = (row_cur >= ROW_W'(WIN_LAST)) && (col_cur >= ADDR_WIDTH'(WIN_LAST));
      if (col_cur == ADDR_WIDTH'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_cur == ROW_W'(IMG_HEIGHT - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_cur + 1'b1;
        end
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  // Shift each row's tap into its 3-deep register on every accepted pixel.
  always_comb begin
    sr_d = sr_q;
    if (I_de) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_LAST; c++) begin
          sr_d[r][c] = sr_q[r][c + 1];
        end
        sr_d[r][WIN_LAST] = tap[r];
      end
    end
  end

  // Capture the freshly shifted window only when it is a complete one.
  always_comb begin
    win_d = win_q;
    de_d  = win_vld;
    vs_d  = I_vsync;
    if (win_vld) begin
      win_d = sr_d;
    end
  end

  // State registers; everything visible clears asynchronously on reset.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      col_q <= '0;
      row_q <= '0;
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      sr_q  <= '{default: '0};
      win_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      de_q  <= de_d;
      vs_q  <= vs_d;
      sr_q  <= sr_d;
      win_q <= win_d;
    end
  end

  assign O_de    = de_q;
  assign O_vsync = vs_q;
  assign O_m11   = win_q[0][0];
  assign O_m12   = win_q[0][1];
  assign O_m13   = win_q[0][2];
  assign O_m21   = win_q[1][0];
  assign O_m22   = win_q[1][1];
  assign O_m23   = win_q[1][2];
  assign O_m31   = win_q[2][0];
  assign O_m32   = win_q[2][1];
  assign O_m33   = win_q[2][2];

endmodule

// File: doc/matrix_3x3_gen.md
MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 Parameters (one per line: name, default, meaning):
  DATA_WIDTH, 8, pixel width
  IMG_WIDTH, 640, active pixels per line
  IMG_HEIGHT, 480, active lines per frame
  ADDR_WIDTH, 10, column counter width; 2**ADDR_WIDTH >= IMG_WIDTH
REQ-002 Ports (one per line: name, direction, width, meaning):
  I_CLK  in  1  single clock, rising edge
  I_Rst_n  in  1  asynchronous active-low reset
  I_vsync  in  1  one-cycle frame-start pulse
  I_de  in  1  input pixel valid
  I_data  in  DATA_WIDTH  input pixel, raster order
  O_de  out  1  window valid
  O_vsync  out  1  I_vsync delayed one cycle
  O_m11..O_m33  out  DATA_WIDTH each  3x3 window; row 1 oldest line, column 1 oldest pixel
REQ-003 One clock, I_CLK; reset I_Rst_n is asynchronous, active-low; no other clock or reset.

Function
REQ-004 col counter (0..IMG_WIDTH-1) increments on I_de and wraps to 0 after IMG_WIDTH-1; row counter (0..IMG_HEIGHT-1) increments on each col wrap and wraps to 0 after IMG_HEIGHT-1.
REQ-005 I_vsync clears col and row; if I_vsync and I_de occur together, that pixel is counted as (row 0, col 0).
REQ-006 Two cascaded line delays of exactly IMG_WIDTH I_de-samples provide taps: row3 = I_data, row2 = I_data delayed one line, row1 = I_data delayed two lines.
REQ-007 Line delays advance only on I_de; with I_de low, no contents, pointers or taps change.
REQ-008 Each row feeds a 3-stage shift register advanced on I_de; m_r3 = newest, m_r1 = oldest sample of row r.
REQ-009 O_de asserts exactly one cycle after an accepted pixel with row >= 2 and col >= 2; otherwise low; no padding, so (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-010 When O_de is high the window is centred on input pixel (row-1, col-1) of the triggering pixel; O_m33 equals that pixel.
REQ-011 O_m11..O_m33 hold their last values while O_de is low.
REQ-012 Line-delay contents are not cleared at frame start; row >= 2 gating alone excludes stale data.
REQ-013 A line cut short by I_vsync discards its partial window state; no O_de from pixels preceding the pulse is emitted after O_vsync.
REQ-014 Pixels beyond IMG_HEIGHT*IMG_WIDTH without I_vsync are treated as a new frame (counters wrapped per REQ-004).
REQ-015 Throughput one pixel per cycle, back-to-back I_de sustained indefinitely.

Reset
REQ-016 While I_Rst_n is low: O_de, O_vsync, O_m11..O_m33, col, row, line-delay pointers and shift registers SHALL be 0, asynchronously.
REQ-017 Line-delay RAM contents need not be reset.
REQ-018 Reset asserted mid-frame aborts the frame; after release, no O_de until a full two lines plus three pixels are re-accepted.

Structure
REQ-019 A shared package holds DATA_WIDTH, IMG_WIDTH, IMG_HEIGHT, ADDR_WIDTH defaults and the window-size constant 3.
REQ-020 One sub-module, line_delay (DATA_WIDTH, IMG_WIDTH, ADDR_WIDTH), a read-before-write RAM delay of IMG_WIDTH samples enabled by I_de, instantiated twice.

Verification (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col)
REQ-021 Reset, I_vsync, 20 back-to-back pixels -> first O_de one cycle after pixel 0x22; window 00,01,02 / 10,11,12 / 20,21,22.
REQ-022 Same frame -> exactly 6 O_de pulses; last window centred 0x23, O_m33 = 0x34.
REQ-023 Same frame with I_de low on alternate cycles -> identical window sequence; outputs stable during gaps.
REQ-024 Second frame without reset -> same 6 windows; no O_de in rows 0-1 despite stale line data.
REQ-025 I_vsync at pixel 0x12, then full frame -> counters restart; no spurious O_de; 6 correct windows.
REQ-026 I_Rst_n low for 2 cycles at pixel 0x31 -> all outputs 0 immediately; no O_de until 0x22 of next frame.
